type_buffer: RTL and testbench

TYPE_BUFFER -- requirements
Module: type_buffer

---
 rtl/type_buffer.sv | 175 +++++++++++++++++
 tb/tb_type_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/type_buffer.sv
// type_buffer: holds the letters typed so far against a latched target word,
// tracks the correctly typed prefix and reports submit success or failure.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   load             latch target/target_len, clear buffer, go IDLE
//   target           target word, char i at [i*CW +: CW]
//   target_len       target length
//   key_valid        letter key pulse with key_code (1..26 accepted)
//   key_bs           backspace pulse
//   key_enter        submit pulse
//   text             typed chars, same packing as target, unused slots 0
//   tot              number of typed chars
//   correct          length of typed prefix matching the target
//   full             tot == MAXLEN
//   word_done        one-cycle pulse on successful submit
//   word_err         one-cycle pulse on failed submit
//   state            IDLE=0, TYPING=1, DONE=2
module type_buffer #(
    parameter int unsigned MAXLEN = 25,
    parameter int unsigned CW     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [MAXLEN*CW-1:0] target,
    input  logic [5:0]           target_len,
    input  logic                 key_valid,
    input  logic [CW-1:0]        key_code,
    input  logic                 key_bs,
    input  logic                 key_enter,
    output logic [MAXLEN*CW-1:0] text,
    output logic [5:0]           tot,
    output logic [5:0]           correct,
    output logic                 full,
    output logic                 word_done,
    output logic                 word_err,
    output logic [1:0]           state
);

    localparam int unsigned TW = 6;
    localparam int unsigned BW = MAXLEN * CW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TYPING = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   text_q, text_d;
    logic [BW-1:0]   tgt_q, tgt_d;
    logic [TW-1:0]   tot_q, tot_d;
    logic [TW-1:0]   cor_q, cor_d;
    logic [TW-1:0]   tlen_q, tlen_d;
    logic            full_q, full_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [CW-1:0]   cur_tgt_ch;
    logic            letter_ok;

    // Target character at the slot the next key would fill
    always_comb begin
        cur_tgt_ch = '0;
        for (int i = 0; i < int'(MAXLEN); i++) begin
            if (TW'(i) == tot_q) cur_tgt_ch = tgt_q[i*CW +: CW];
        end
    end

    assign letter_ok = (key_code != '0) && (key_code <= CW'(26));

    // Next-state logic: one event per cycle, load > enter > bs > key
    always_comb begin
        state_d = state_q;
        text_d  = text_q;
        tgt_d   = tgt_q;
        tot_d   = tot_q;
        cor_d   = cor_q;
        tlen_d  = tlen_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (load) begin
            tgt_d   = target;
            tlen_d  = target_len;
            text_d  = '0;
            tot_d   = '0;
            cor_d   = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, TYPING: begin
                    if (key_enter) begin
                        // IDLE has nothing to submit; the event is consumed
                        if (state_q == TYPING) begin
                            if (tot_q != '0 && tot_q == tlen_q && cor_q == tlen_q) begin
                                done_d  = 1'b1;
                                state_d = DONE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end else if (key_bs) begin
                        if (state_q == TYPING && tot_q != '0) begin
                            for (int i = 0; i < int'(MAXLEN); i++) begin
                                if (TW'(i) == tot_q - TW'(1)) text_d[i*CW +: CW] = '0;
                            end
                            tot_d = tot_q - TW'(1);
                            if (cor_q == tot_q) cor_d = cor_q - TW'(1);
                            if (tot_q == TW'(1)) state_d = IDLE;
                        end
                    end else if (key_valid && letter_ok && tot_q < TW'(MAXLEN)) begin
                        for (int i = 0; i < int'(MAXLEN); i++) begin
                            if (TW'(i) == tot_q) text_d[i*CW +: CW] = key_code;
                        end
                        tot_d = tot_q + TW'(1);
                        // Prefix only grows while it is unbroken and within the target
                        if (cor_q == tot_q && key_code == cur_tgt_ch && tot_q < tlen_q)
                            cor_d = cor_q + TW'(1);
                        state_d = TYPING;
                    end
                end
                DONE: begin
                    text_d  = '0;
                    tot_d   = '0;
                    cor_d   = '0;
                    state_d = IDLE;
                end
                default: begin
                    text_d  = '0;
                    tot_d   = '0;
                    cor_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end

        full_d = (tot_d == TW'(MAXLEN));
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            text_q  <= '0;
            tgt_q   <= '0;
            tot_q   <= '0;
            cor_q   <= '0;
            tlen_q  <= '0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            text_q  <= text_d;
            tgt_q   <= tgt_d;
            tot_q   <= tot_d;
            cor_q   <= cor_d;
            tlen_q  <= tlen_d;
            full_q  <= full_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign text      = text_q;
    assign tot       = tot_q;
    assign correct   = cor_q;
    assign full      = full_q;
    assign word_done = done_q;
    assign word_err  = err_q;
    assign state     = 2'(state_q);

endmodule

// File: tb/tb_type_buffer.sv
// Directed bench for type_buffer: expected outputs queued with each stimulus
// step and compared one cycle later.
module tb_type_buffer;

    localparam int unsigned MAXLEN = 25;
    localparam int unsigned CW     = 5;
    localparam int unsigned BW     = MAXLEN * CW;
    localparam logic [1:0] S_IDLE = 2'd0, S_TYP = 2'd1, S_DONE = 2'd2;

    logic          clk = 1'b0;
    logic          rst, load, key_valid, key_bs, key_enter;
    logic [BW-1:0] target, text;
    logic [5:0]    target_len, tot, correct;
    logic [CW-1:0] key_code;
    logic          full, word_done, word_err;
    logic [1:0]    state;

    typedef struct {
        string         tag;
        logic [BW-1:0] text;
        logic [5:0]    tot;
        logic [5:0]    cor;
        logic          full;
        logic          done;
        logic          err;
        logic [1:0]    st;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    type_buffer #(.MAXLEN(MAXLEN), .CW(CW)) dut (
        .clk(clk), .rst(rst), .load(load), .target(target), .target_len(target_len),
        .key_valid(key_valid), .key_code(key_code), .key_bs(key_bs), .key_enter(key_enter),
        .text(text), .tot(tot), .correct(correct), .full(full),
        .word_done(word_done), .word_err(word_err), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [BW-1:0] mk(input int a, input int b, input int c, input int d);
        logic [BW-1:0] v;
        v = '0;
        v[0*CW +: CW] = CW'(a);
        v[1*CW +: CW] = CW'(b);
        v[2*CW +: CW] = CW'(c);
        v[3*CW +: CW] = CW'(d);
        return v;
    endfunction

    function automatic logic [BW-1:0] ones(input int n);
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i*CW +: CW] = CW'(1);
        return v;
    endfunction

    task automatic chk(input string tag, input string fld, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [BW-1:0] tx, input int t, input int c,
                        input logic f, input logic d, input logic e, input logic [1:0] s);
        exp_t x;
        x.tag = tag; x.text = tx; x.tot = 6'(t); x.cor = 6'(c);
        x.full = f; x.done = d; x.err = e; x.st = s;
        sbq.push_back(x);
    endtask

    // Advance one edge, clear pulses, compare DUT against the oldest expectation
    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        rst = 0; load = 0; key_valid = 0; key_code = '0; key_bs = 0; key_enter = 0;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard observed=empty expected=entry");
        end else begin
            x = sbq.pop_front();
            chk(x.tag, "text", text, x.text);
            chk(x.tag, "tot", BW'(tot), BW'(x.tot));
            chk(x.tag, "correct", BW'(correct), BW'(x.cor));
            chk(x.tag, "full", BW'(full), BW'(x.full));
            chk(x.tag, "word_done", BW'(word_done), BW'(x.done));
            chk(x.tag, "word_err", BW'(word_err), BW'(x.err));
            chk(x.tag, "state", BW'(state), BW'(x.st));
        end
    endtask

    task automatic key(input int code);
        key_valid = 1; key_code = CW'(code);
    endtask

    task automatic do_load(input logic [BW-1:0] t, input int n);
        load = 1; target = t; target_len = 6'(n);
    endtask

    localparam logic [BW-1:0] Z = '0;

    initial begin
        rst = 1; load = 0; key_valid = 0; key_code = '0; key_bs = 0; key_enter = 0;
        target = '0; target_len = '0;

        push("reset", Z, 0, 0, 0, 0, 0, S_IDLE); tick();

        // Submit before any load never matches
        key(5);            push("pre_key", mk(5,0,0,0), 1, 0, 0, 0, 0, S_TYP); tick();
        key_enter = 1;     push("pre_enter", mk(5,0,0,0), 1, 0, 0, 0, 1, S_TYP); tick();

        // Load CAT, backspace in IDLE ignored, invalid codes ignored
        do_load(mk(3,1,20,0), 3); push("load_cat", Z, 0, 0, 0, 0, 0, S_IDLE); tick();
        key_bs = 1;        push("bs_idle", Z, 0, 0, 0, 0, 0, S_IDLE); tick();
        key(27);           push("key27", Z, 0, 0, 0, 0, 0, S_IDLE); tick();
        key(0);            push("key0", Z, 0, 0, 0, 0, 0, S_IDLE); tick();

        // Correct word
        key(3);            push("cat_c", mk(3,0,0,0), 1, 1, 0, 0, 0, S_TYP); tick();
        key(1);            push("cat_a", mk(3,1,0,0), 2, 2, 0, 0, 0, S_TYP); tick();
        key(20);           push("cat_t", mk(3,1,20,0), 3, 3, 0, 0, 0, S_TYP); tick();
        key_enter = 1;     push("cat_enter", mk(3,1,20,0), 3, 3, 0, 1, 0, S_DONE); tick();
        key(5);            push("done_key", Z, 0, 0, 0, 0, 0, S_IDLE); tick();

        // Typo, failed submit, repair
        key(3);            push("cot_c", mk(3,0,0,0), 1, 1, 0, 0, 0, S_TYP); tick();
        key(15);           push("cot_o", mk(3,15,0,0), 2, 1, 0, 0, 0, S_TYP); tick();
        key(20);           push("cot_t", mk(3,15,20,0), 3, 1, 0, 0, 0, S_TYP); tick();
        key_enter = 1;     push("cot_enter", mk(3,15,20,0), 3, 1, 0, 0, 1, S_TYP); tick();
        push("err_clear", mk(3,15,20,0), 3, 1, 0, 0, 0, S_TYP); tick();
        key_bs = 1;        push("cot_bs1", mk(3,15,0,0), 2, 1, 0, 0, 0, S_TYP); tick();
        key_bs = 1;        push("cot_bs2", mk(3,0,0,0), 1, 1, 0, 0, 0, S_TYP); tick();
        key(1);            push("fix_a", mk(3,1,0,0), 2, 2, 0, 0, 0, S_TYP); tick();
        key(20);           push("fix_t", mk(3,1,20,0), 3, 3, 0, 0, 0, S_TYP); tick();
        key(1);            push("over_len", mk(3,1,20,1), 4, 3, 0, 0, 0, S_TYP); tick();
        key_bs = 1;        push("over_bs", mk(3,1,20,0), 3, 3, 0, 0, 0, S_TYP); tick();
        key_enter = 1;     push("fix_enter", mk(3,1,20,0), 3, 3, 0, 1, 0, S_DONE); tick();
        push("done_exit", Z, 0, 0, 0, 0, 0, S_IDLE); tick();

        // Simultaneous events: enter wins
        do_load(mk(3,1,20,0), 3); push("load2", Z, 0, 0, 0, 0, 0, S_IDLE); tick();
        key(3);            push("s_c", mk(3,0,0,0), 1, 1, 0, 0, 0, S_TYP); tick();
        key(1);            push("s_a", mk(3,1,0,0), 2, 2, 0, 0, 0, S_TYP); tick();
        key(5); key_bs = 1; key_enter = 1;
                           push("simul", mk(3,1,0,0), 2, 2, 0, 0, 1, S_TYP); tick();
        key(1); key_bs = 1; push("bs_over_key", mk(3,0,0,0), 1, 1, 0, 0, 0, S_TYP); tick();
        key_bs = 1;        push("bs_to_idle", Z, 0, 0, 0, 0, 0, S_IDLE); tick();

        // Load overrides keys in the same cycle
        do_load(mk(3,1,20,0), 3); key(3);
                           push("load_prio", Z, 0, 0, 0, 0, 0, S_IDLE); tick();

        // Reset mid-typing clears the latched target too
        key(3);            push("r_c", mk(3,0,0,0), 1, 1, 0, 0, 0, S_TYP); tick();
        key(1);            push("r_a", mk(3,1,0,0), 2, 2, 0, 0, 0, S_TYP); tick();
        key(5);            push("r_e", mk(3,1,5,0), 3, 2, 0, 0, 0, S_TYP); tick();
        key(5);            push("r_e2", mk(3,1,5,5), 4, 2, 0, 0, 0, S_TYP); tick();
        rst = 1; key_enter = 1;
                           push("mid_rst", Z, 0, 0, 0, 0, 0, S_IDLE); tick();
        key(3);            push("post_rst_key", mk(3,0,0,0), 1, 0, 0, 0, 0, S_TYP); tick();
        key_enter = 1;     push("post_rst_enter", mk(3,0,0,0), 1, 0, 0, 0, 1, S_TYP); tick();

        // Saturation at MAXLEN
        do_load(mk(3,1,20,0), 3); push("load3", Z, 0, 0, 0, 0, 0, S_IDLE); tick();
        for (int i = 1; i <= int'(MAXLEN); i++) begin
            key(1);
            push($sformatf("fill%0d", i), ones(i), i, 0, (i == int'(MAXLEN)), 0, 0, S_TYP);
            tick();
        end
        key(1);            push("fill26", ones(MAXLEN), MAXLEN, 0, 1, 0, 0, S_TYP); tick();
        key_bs = 1;        push("full_bs", ones(MAXLEN-1), MAXLEN-1, 0, 0, 0, 0, S_TYP); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
